// File: rtl/imm_encode.sv
// Pipelined RISC-V immediate encoder: scatters an immediate into the I/S/B/U/J
// field positions of an instruction template. Range checking is enabled by IMM_ENC_RANGE_CHK_EN.
module imm_encode #(
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt
);

  localparam logic [2:0] OP_I = 3'd0;
  localparam logic [2:0] OP_S = 3'd1;
  localparam logic [2:0] OP_B = 3'd2;
  localparam logic [2:0] OP_U = 3'd3;
  localparam logic [2:0] OP_J = 3'd4;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and data stable until that transfer, and ready never
  // depends combinationally on the same side's valid.
  logic        s1_valid;
  logic [2:0]  s1_op;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s2_adv;
  logic        s1_adv;
  logic [31:0] field_mask;
  logic [31:0] scat_imm;
  logic [31:0] enc_inst;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    field_mask = '0;
    scat_imm   = '0;
    case (s1_op)
      OP_I: begin
        field_mask = 32'hFFF0_0000;
        scat_imm   = {s1_imm[11:0], 20'd0};
      end
      OP_S: begin
        field_mask = 32'hFE00_0F80;
        scat_imm   = {s1_imm[11:5], 13'd0, s1_imm[4:0], 7'd0};
      end
      OP_B: begin
        field_mask = 32'hFE00_0F80;
        scat_imm   = {s1_imm[12], s1_imm[10:5], 13'd0, s1_imm[4:1], s1_imm[11], 7'd0};
      end
      OP_U: begin
        field_mask = 32'hFFFF_F000;
        scat_imm   = {s1_imm[31:12], 12'd0};
      end
      OP_J: begin
        field_mask = 32'hFFFF_F000;
        scat_imm   = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'd0};
      end
      default: begin
        field_mask = '0;
        scat_imm   = '0;
      end
    endcase
  end

  assign enc_inst = (s1_base & ~field_mask) | scat_imm;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_imm    <= '0;
      s1_base   <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      enc_cnt   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op   <= in_op;
          s1_imm  <= in_imm;
          s1_base <= in_base;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_inst <= enc_inst;
        end
      end
      if (out_valid && out_ready) begin
        enc_cnt <= enc_cnt + 1'b1;
      end
    end
  end

`ifdef IMM_ENC_RANGE_CHK_EN
  logic in_rng_err;
  logic s1_err;

  // Error whenever the immediate does not fit the signed/aligned field width.
  always_comb begin
    in_rng_err = 1'b1;
    case (in_op)
      OP_I, OP_S: in_rng_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      OP_B:       in_rng_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      OP_U:       in_rng_err = |in_imm[11:0];
      OP_J:       in_rng_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:    in_rng_err = 1'b1;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      s1_err  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (s1_adv && in_valid) begin
        s1_err <= in_rng_err;
      end
      if (s2_adv && s1_valid) begin
        out_err <= s1_err;
      end
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed vector table, backpressure and
// reset sequences, and randomized traffic against a behavioural scoreboard.
module tb_imm_encode;

`ifdef IMM_ENC_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        cpu_clk;
  logic        cpu_rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_cnt;

  imm_encode #(.CNT_W(16)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_imm   (in_imm),
    .in_base  (in_base),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_err  (out_err),
    .enc_cnt  (enc_cnt)
  );

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t        vecs[10];
  logic [32:0] exp_q[$];
  int          errs;
  int          checks;
  int          acc_n;
  int          k;
  bit          took;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural reference: signed ranges and shift/mask arithmetic
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] imm,
                                        input logic [31:0] base);
    int          s;
    logic [31:0] mask;
    logic [31:0] fld;
    bit          e;
    s = imm;
    case (op)
      3'd0: begin
        mask = 32'hFFF00000;
        fld  = (imm & 32'hFFF) << 20;
        e    = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        mask = 32'hFE000F80;
        fld  = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        e    = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        mask = 32'hFE000F80;
        fld  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
               (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        e    = (s < -4096) || (s > 4095) || ((s & 1) != 0);
      end
      3'd3: begin
        mask = 32'hFFFFF000;
        fld  = imm & 32'hFFFFF000;
        e    = (imm % 4096) != 0;
      end
      3'd4: begin
        mask = 32'hFFFFF000;
        fld  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
               (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        e    = (s < -(1 << 20)) || (s >= (1 << 20)) || ((s & 1) != 0);
      end
      default: begin
        mask = 32'h0;
        fld  = 32'h0;
        e    = 1'b1;
      end
    endcase
    return {CHK ? e : 1'b0, (base & ~mask) | fld};
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = $urandom_range(0, 10000) - 32'd5000;
      2:       v = $urandom & 32'hFFFFF000;
      default: v = ($urandom_range(0, 32'h400000) - 32'h200000) & ~32'h1;
    endcase
    return v;
  endfunction

  // scoreboard: pops on output handshake, pushes on input handshake
  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge cpu_clk);
      if (cpu_rst) begin
        exp_q.delete();
        acc_n = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_inst", out_inst, e[31:0]);
            chk("sb_err", {31'd0, out_err}, {31'd0, e[32]});
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in_op, in_imm, in_base));
          acc_n++;
        end
      end
    end
  endtask

  // driver tasks
  task automatic set_req(input int i);
    in_op   = vecs[i].op;
    in_imm  = vecs[i].imm;
    in_base = vecs[i].base;
  endtask

  task automatic do_reset();
    cpu_rst  = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1 cpu_rst = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int lat;
    bit acc;
    set_req(i);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 8 && !acc; c++) begin
      @(negedge cpu_clk);
      acc = in_ready;
      @(posedge cpu_clk);
      #1;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_accept", i), {31'd0, acc}, 32'd1);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge cpu_clk);
      lat++;
      if (out_valid) break;
    end
    chk($sformatf("v%0d_latency", i), lat, 32'd2);
    chk($sformatf("v%0d_inst", i), out_inst, vecs[i].inst);
    chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, CHK ? vecs[i].err : 1'b0});
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic feed(input int n, input int budget);
    k = 0;
    set_req(0);
    in_valid = 1'b1;
    for (int c = 0; c < budget && !(k == n && exp_q.size() == 0 && out_ready); c++) begin
      @(negedge cpu_clk);
      took = in_valid && in_ready;
      @(posedge cpu_clk);
      #1;
      if (took) begin
        k++;
        if (k < n) set_req(k);
        else in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
    vecs[1] = '{3'd2, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0};
    vecs[2] = '{3'd4, 32'h00000008, 32'h000000EF, 32'h008000EF, 1'b0};
    vecs[3] = '{3'd3, 32'h12345000, 32'h000002B7, 32'h123452B7, 1'b0};
    vecs[4] = '{3'd3, 32'h12345001, 32'h000002B7, 32'h123452B7, 1'b1};
    vecs[5] = '{3'd1, 32'h00000800, 32'h00112023, 32'h80112023, 1'b1};
    vecs[6] = '{3'd6, 32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[7] = '{3'd0, 32'h000007FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0};
    vecs[8] = '{3'd2, 32'h00000FFE, 32'h00000000, 32'h7E000F80, 1'b0};
    vecs[9] = '{3'd4, 32'h00100000, 32'h00000000, 32'h80000000, 1'b1};

    errs = 0; checks = 0; acc_n = 0;
    in_op = '0; in_imm = '0; in_base = '0; out_ready = 1'b1;
    do_reset();
    fork
      monitor();
    join_none

    @(negedge cpu_clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge cpu_clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(i);
    @(negedge cpu_clk);
    chk("table_enc_cnt", {16'd0, enc_cnt}, 32'd10);
    @(posedge cpu_clk);
    #1;

    // backpressure: only two words fit with the consumer stalled
    do_reset();
    out_ready = 1'b0;
    feed(4, 4);
    chk("bp_accepted", k, 32'd2);
    @(negedge cpu_clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge cpu_clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_inst", out_inst, vecs[0].inst);
      chk("bp_hold_err", {31'd0, out_err}, {31'd0, CHK ? vecs[0].err : 1'b0});
    end
    @(posedge cpu_clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 16 && !(k == 4 && exp_q.size() == 0); c++) begin
      @(negedge cpu_clk);
      took = in_valid && in_ready;
      @(posedge cpu_clk);
      #1;
      if (took) begin
        k++;
        if (k < 4) set_req(k);
        else in_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", k, 32'd4);
    chk("bp_drained", exp_q.size(), 32'd0);
    @(negedge cpu_clk);
    chk("bp_enc_cnt", {16'd0, enc_cnt}, 32'd4);

    // reset with two words in flight
    @(posedge cpu_clk);
    #1;
    out_ready = 1'b0;
    feed(2, 4);
    @(negedge cpu_clk);
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    @(posedge cpu_clk);
    #1 cpu_rst = 1'b1;
    @(posedge cpu_clk);
    #1 cpu_rst = 1'b0;
    @(negedge cpu_clk);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge cpu_clk);
    #1;

    // randomized traffic with random backpressure
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge cpu_clk);
      took = in_valid && in_ready;
      @(posedge cpu_clk);
      #1;
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 3'($urandom_range(0, 7));
        in_imm   = rand_imm();
        in_base  = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && in_valid; c++) begin
      @(negedge cpu_clk);
      took = in_valid && in_ready;
      @(posedge cpu_clk);
      #1;
      if (took) in_valid = 1'b0;
    end
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_enc_cnt", {16'd0, enc_cnt}, acc_n);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
